// File: rtl/snoopy_vertical_physics.sv
// snoopy_vertical_physics
//   Vertical motion controller for the Snoopy sprite. Physics advance once
//   per frame on the tick strobe. Velocity and gravity use semi-implicit Euler
//   integration. The controller clamps at the ground and the ceiling and
//   limits the number of jumps allowed between landings.
//
// Ports
//   clock       system clock
//   reset       asynchronous active-low reset
//   tick        one-cycle frame strobe; physics advance only on it
//   input_jump  jump button level (already synchronised)
//   freeze      pause level; ticks are ignored while high
//   snoopy_y    current row (y grows downward)
//   velocity    signed rows/frame (negative = upward)
//   state       00 GROUND, 01 RISE, 10 FALL (11 illegal, recovers to FALL)
//   jump_count  jumps used since the last landing
//   on_ground   high iff state == GROUND
//   landed      one-cycle pulse on the tick that lands
//
// Handshake: none. tick is a qualifier strobe with no back-pressure. A jump
// press is a request that stays pending until the next tick that is not
// frozen consumes it. The press is consumed even if the jump budget is spent.
module snoopy_vertical_physics #(
  parameter int Y_WIDTH      = 8,
  parameter int V_WIDTH      = 6,
  parameter int GROUND_Y     = 104,
  parameter int CEIL_Y       = 0,
  parameter int JUMP_VEL     = 12,
  parameter int GRAVITY      = 1,
  parameter int MAX_FALL_VEL = 15,
  parameter int MAX_JUMPS    = 2
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                tick,
  input  logic                                input_jump,
  input  logic                                freeze,
  output logic [Y_WIDTH-1:0]                  snoopy_y,
  output logic signed [V_WIDTH-1:0]           velocity,
  output logic [1:0]                          state,
  output logic [$clog2(MAX_JUMPS+1)-1:0]      jump_count,
  output logic                                on_ground,
  output logic                                landed
);

  localparam int JCW = $clog2(MAX_JUMPS + 1);
  localparam int YW2 = Y_WIDTH + 2;
  localparam int VW2 = V_WIDTH + 2;

  localparam logic [1:0] S_GROUND  = 2'b00;
  localparam logic [1:0] S_RISE    = 2'b01;
  localparam logic [1:0] S_FALL    = 2'b10;
  localparam logic [1:0] S_ILLEGAL = 2'b11;

  localparam logic signed [VW2-1:0] L_GRAV   = VW2'(GRAVITY);
  localparam logic signed [VW2-1:0] L_VMAX   = VW2'((1 << (V_WIDTH - 1)) - 1);
  localparam logic signed [VW2-1:0] L_VMIN   = VW2'(-(1 << (V_WIDTH - 1)));
  localparam logic signed [VW2-1:0] L_MAXF   = VW2'(MAX_FALL_VEL);
  localparam logic signed [VW2-1:0] L_NEG_JV = VW2'(-JUMP_VEL);
  localparam logic signed [YW2-1:0] L_GROUND = YW2'(GROUND_Y);
  localparam logic signed [YW2-1:0] L_CEIL   = YW2'(CEIL_Y);
  localparam logic [JCW-1:0]        L_MAXJ   = JCW'(MAX_JUMPS);

  logic [Y_WIDTH-1:0]        r_y;
  logic signed [V_WIDTH-1:0] r_vel;
  logic [1:0]                r_state;
  logic [JCW-1:0]            r_cnt;
  logic                      r_landed;
  logic                      r_pending;
  logic                      r_prev;
  // A press counts only after the button has been seen released once
  // since reset. A button held through reset therefore never fires a jump.
  logic                      r_armed;

  logic                      w_jump_edge;
  logic                      w_req;
  logic                      w_accept;
  logic                      w_tick_go;
  logic signed [VW2-1:0]     w_vel_ext;
  logic signed [VW2-1:0]     w_vel_grav;
  logic signed [VW2-1:0]     w_vel_sat;
  logic signed [VW2-1:0]     w_vel_fall;
  logic signed [VW2-1:0]     w_vel_cand;
  logic signed [YW2-1:0]     w_y_ext;
  logic signed [YW2-1:0]     w_y_prop;
  logic [1:0]                w_state_cand;
  logic                      w_move;
  logic [Y_WIDTH-1:0]        w_y_n;
  logic signed [V_WIDTH-1:0] w_vel_n;
  logic [1:0]                w_state_n;
  logic [JCW-1:0]            w_cnt_n;
  logic                      w_land;

  assign w_jump_edge = input_jump & ~r_prev & r_armed;
  assign w_req       = r_pending | w_jump_edge;
  assign w_accept    = w_req & (r_cnt < L_MAXJ);
  assign w_tick_go   = tick & ~freeze;

  always_comb begin
    w_vel_ext  = {{2{r_vel[V_WIDTH-1]}}, r_vel};
    w_vel_grav = w_vel_ext + L_GRAV;
    if (w_vel_grav > L_VMAX)      w_vel_sat = L_VMAX;
    else if (w_vel_grav < L_VMIN) w_vel_sat = L_VMIN;
    else                          w_vel_sat = w_vel_grav;
    w_vel_fall = (w_vel_sat > L_MAXF) ? L_MAXF : w_vel_sat;
    w_y_ext    = {2'b00, r_y};

    w_move       = 1'b0;
    w_vel_cand   = '0;
    w_state_cand = r_state;
    w_y_n        = r_y;
    w_vel_n      = r_vel;
    w_state_n    = r_state;
    w_cnt_n      = r_cnt;
    w_land       = 1'b0;

    if (r_state == S_ILLEGAL) begin
      w_state_n = S_FALL;
    end else if (w_accept) begin
      w_move       = 1'b1;
      w_vel_cand   = L_NEG_JV;
      w_state_cand = S_RISE;
      w_cnt_n      = r_cnt + JCW'(1);
    end else if (r_state == S_RISE) begin
      w_move       = 1'b1;
      w_vel_cand   = w_vel_sat;
      w_state_cand = w_vel_sat[VW2-1] ? S_RISE : S_FALL;
    end else if (r_state == S_FALL) begin
      w_move       = 1'b1;
      w_vel_cand   = w_vel_fall;
      w_state_cand = S_FALL;
    end

    // Position is computed with two spare bits so that overshoot past either
    // boundary is detected instead of wrapping.
    w_y_prop = w_y_ext + YW2'(w_vel_cand);

    if (w_move) begin
      if (w_y_prop >= L_GROUND) begin
        w_y_n     = Y_WIDTH'(GROUND_Y);
        w_vel_n   = '0;
        w_state_n = S_GROUND;
        w_cnt_n   = '0;
        w_land    = 1'b1;
      end else if (w_y_prop < L_CEIL) begin
        w_y_n     = Y_WIDTH'(CEIL_Y);
        w_vel_n   = '0;
        w_state_n = S_FALL;
      end else begin
        w_y_n     = w_y_prop[Y_WIDTH-1:0];
        w_vel_n   = w_vel_cand[V_WIDTH-1:0];
        w_state_n = w_state_cand;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_y       <= Y_WIDTH'(GROUND_Y);
      r_vel     <= '0;
      r_state   <= S_GROUND;
      r_cnt     <= '0;
      r_landed  <= 1'b0;
      r_pending <= 1'b0;
      r_prev    <= 1'b0;
      r_armed   <= 1'b0;
    end else begin
      r_prev   <= input_jump;
      r_armed  <= r_armed | ~input_jump;
      r_landed <= w_tick_go & w_land;
      if (w_tick_go) begin
        r_pending <= 1'b0;
        r_y       <= w_y_n;
        r_vel     <= w_vel_n;
        r_state   <= w_state_n;
        r_cnt     <= w_cnt_n;
      end else if (w_jump_edge) begin
        r_pending <= 1'b1;
      end
    end
  end

  assign snoopy_y   = r_y;
  assign velocity   = r_vel;
  assign state      = r_state;
  assign jump_count = r_cnt;
  assign on_ground  = (r_state == S_GROUND);
  assign landed     = r_landed;

endmodule

// File: tb/tb_snoopy_vertical_physics.sv
module tb_snoopy_vertical_physics;

  // ---------------- clock / reset / DUTs ----------------
  logic clock;
  logic reset;
  logic tick;
  logic input_jump;
  logic freeze;

  logic [7:0]        y_o  [3];
  logic signed [5:0] v_o  [3];
  logic [1:0]        st_o [3];
  logic [1:0]        jc_o [3];
  logic              og_o [3];
  logic              ld_o [3];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // inst 0: defaults; inst 1: raised ceiling; inst 2: deep ground, strong jump
  snoopy_vertical_physics u0 (
    .clock(clock), .reset(reset), .tick(tick), .input_jump(input_jump),
    .freeze(freeze), .snoopy_y(y_o[0]), .velocity(v_o[0]), .state(st_o[0]),
    .jump_count(jc_o[0]), .on_ground(og_o[0]), .landed(ld_o[0]));

  snoopy_vertical_physics #(.CEIL_Y(40)) u1 (
    .clock(clock), .reset(reset), .tick(tick), .input_jump(input_jump),
    .freeze(freeze), .snoopy_y(y_o[1]), .velocity(v_o[1]), .state(st_o[1]),
    .jump_count(jc_o[1]), .on_ground(og_o[1]), .landed(ld_o[1]));

  snoopy_vertical_physics #(.GROUND_Y(250), .JUMP_VEL(21)) u2 (
    .clock(clock), .reset(reset), .tick(tick), .input_jump(input_jump),
    .freeze(freeze), .snoopy_y(y_o[2]), .velocity(v_o[2]), .state(st_o[2]),
    .jump_count(jc_o[2]), .on_ground(og_o[2]), .landed(ld_o[2]));

  // ---------------- reference model ----------------
  int P_G  [3] = '{104, 104, 250};
  int P_C  [3] = '{0, 40, 0};
  int P_JV [3] = '{12, 12, 21};
  localparam int MAXJ = 2;
  localparam int VMAX = 31;
  localparam int TERM = 15;

  int m_y [3];
  int m_v [3];
  int m_st[3];
  int m_cnt[3];
  bit m_land[3];
  bit m_pend[3];
  bit m_prev[3];

  int n_pass;
  int n_total;

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) begin
      m_y[i] = P_G[i]; m_v[i] = 0; m_st[i] = 0; m_cnt[i] = 0;
      m_land[i] = 0; m_pend[i] = 0;
      // a button already down at reset is not a new press
      m_prev[i] = 1;
    end
  endfunction

  function automatic void model_update(input bit t, input bit j, input bit f);
    for (int i = 0; i < 3; i++) begin
      bit press;
      bit req;
      bit moved;
      int ny;
      press = j && !m_prev[i];
      m_prev[i] = j;
      req = m_pend[i] || press;
      m_land[i] = 0;
      if (t && !f) begin
        m_pend[i] = 0;
        moved = 1;
        ny = m_y[i];
        if (req && m_cnt[i] < MAXJ) begin
          m_cnt[i]++;
          m_v[i] = -P_JV[i];
          ny = m_y[i] - P_JV[i];
          m_st[i] = 1;
        end else if (m_st[i] == 0) begin
          moved = 0;
        end else begin
          m_v[i] = m_v[i] + 1;
          if (m_v[i] > VMAX) m_v[i] = VMAX;
          if (m_st[i] == 2 && m_v[i] > TERM) m_v[i] = TERM;
          ny = m_y[i] + m_v[i];
          if (m_v[i] >= 0) m_st[i] = 2;
        end
        if (moved) begin
          if (ny >= P_G[i]) begin
            m_y[i] = P_G[i]; m_v[i] = 0; m_st[i] = 0; m_cnt[i] = 0; m_land[i] = 1;
          end else if (ny < P_C[i]) begin
            m_y[i] = P_C[i]; m_v[i] = 0; m_st[i] = 2;
          end else begin
            m_y[i] = ny;
          end
        end
      end else if (press) begin
        m_pend[i] = 1;
      end
    end
  endfunction

  // ---------------- scoreboard ----------------
  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
  endtask

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("model_y[%0d]", i), int'(y_o[i]), m_y[i]);
      chk($sformatf("model_vel[%0d]", i), int'(v_o[i]), m_v[i]);
      chk($sformatf("model_state[%0d]", i), int'(st_o[i]), m_st[i]);
      chk($sformatf("model_jc[%0d]", i), int'(jc_o[i]), m_cnt[i]);
      chk($sformatf("model_on_ground[%0d]", i), int'(og_o[i]), int'(m_st[i] == 0));
      chk($sformatf("model_landed[%0d]", i), int'(ld_o[i]), int'(m_land[i]));
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called at a negedge; drives inputs, lets one clock edge pass, checks.
  task automatic step(input bit t, input bit j, input bit f);
    tick = t; input_jump = j; freeze = f;
    @(posedge clock);
    model_update(t, j, f);
    @(negedge clock);
    check_all();
  endtask

  // Reset asserted between clock edges; its effect is checked before any edge.
  task automatic do_reset(input bit j);
    tick = 1'b0; freeze = 1'b0; input_jump = j;
    #1 reset = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic press_jump(input bit f);
    step(1'b0, 1'b1, f);
    step(1'b0, 1'b0, f);
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    bit jmp;
    int nt;
    bit frz;
    int y;
    int v;
    int st;
    int jc;
    bit ld;
  } vec_t;

  vec_t tbl[16];
  bit   jr;

  initial begin
    n_pass = 0; n_total = 0;
    reset = 1'b0; tick = 1'b0; input_jump = 1'b0; freeze = 1'b0;
    model_reset();

    // single jump, double jump (third press ignored), frozen press, landing
    tbl[0]  = '{1'b1, 1,  1'b0, 92,  -12, 1, 1, 1'b0};
    tbl[1]  = '{1'b0, 12, 1'b0, 26,  0,   2, 1, 1'b0};
    tbl[2]  = '{1'b0, 11, 1'b0, 92,  11,  2, 1, 1'b0};
    tbl[3]  = '{1'b0, 1,  1'b0, 104, 0,   0, 0, 1'b1};
    tbl[4]  = '{1'b1, 1,  1'b0, 92,  -12, 1, 1, 1'b0};
    tbl[5]  = '{1'b0, 1,  1'b0, 81,  -11, 1, 1, 1'b0};
    tbl[6]  = '{1'b1, 1,  1'b0, 69,  -12, 1, 2, 1'b0};
    tbl[7]  = '{1'b0, 1,  1'b0, 58,  -11, 1, 2, 1'b0};
    tbl[8]  = '{1'b1, 1,  1'b0, 48,  -10, 1, 2, 1'b0};
    tbl[9]  = '{1'b0, 10, 1'b0, 3,   0,   2, 2, 1'b0};
    tbl[10] = '{1'b0, 13, 1'b0, 94,  13,  2, 2, 1'b0};
    tbl[11] = '{1'b0, 1,  1'b0, 104, 0,   0, 0, 1'b1};
    tbl[12] = '{1'b1, 3,  1'b1, 104, 0,   0, 0, 1'b0};
    tbl[13] = '{1'b0, 1,  1'b0, 92,  -12, 1, 1, 1'b0};
    tbl[14] = '{1'b0, 23, 1'b0, 92,  11,  2, 1, 1'b0};
    tbl[15] = '{1'b0, 1,  1'b0, 104, 0,   0, 0, 1'b1};

    @(negedge clock);
    do_reset(1'b0);
    chk("reset_y", int'(y_o[0]), 104);
    chk("reset_on_ground", int'(og_o[0]), 1);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);

    for (int r = 0; r < 16; r++) begin
      if (tbl[r].jmp) press_jump(tbl[r].frz);
      for (int k = 0; k < tbl[r].nt; k++) begin
        step(1'b1, 1'b0, tbl[r].frz);
        if (k < tbl[r].nt - 1) step(1'b0, 1'b0, tbl[r].frz);
      end
      chk($sformatf("vec%0d_y", r), int'(y_o[0]), tbl[r].y);
      chk($sformatf("vec%0d_vel", r), int'(v_o[0]), tbl[r].v);
      chk($sformatf("vec%0d_state", r), int'(st_o[0]), tbl[r].st);
      chk($sformatf("vec%0d_jc", r), int'(jc_o[0]), tbl[r].jc);
      chk($sformatf("vec%0d_landed", r), int'(ld_o[0]), int'(tbl[r].ld));
      step(1'b0, 1'b0, 1'b0);
    end

    // ceiling (inst 1), terminal velocity and no-wrap clamp (inst 2)
    do_reset(1'b0);
    step(1'b0, 1'b0, 1'b0);
    press_jump(1'b0);
    for (int k = 1; k <= 45; k++) begin
      step(1'b1, 1'b0, 1'b0);
      if (k == 8) begin
        chk("ceil_y", int'(y_o[1]), 40);
        chk("ceil_vel", int'(v_o[1]), 0);
        chk("ceil_state", int'(st_o[1]), 2);
      end
      if (k == 9) begin
        chk("ceil_next_y", int'(y_o[1]), 41);
        chk("ceil_next_vel", int'(v_o[1]), 1);
      end
      if (k == 1) chk("deep_jump_y", int'(y_o[2]), 229);
      if (k == 22) begin
        chk("deep_apex_y", int'(y_o[2]), 19);
        chk("deep_apex_state", int'(st_o[2]), 2);
      end
      if (k == 37) chk("term_vel", int'(v_o[2]), 15);
      if (k == 38) begin
        chk("term_y38", int'(y_o[2]), 154);
        chk("term_vel38", int'(v_o[2]), 15);
      end
      if (k == 44) chk("term_y44", int'(y_o[2]), 244);
      if (k == 45) begin
        chk("deep_land_y", int'(y_o[2]), 250);
        chk("deep_land_pulse", int'(ld_o[2]), 1);
      end
      if (k == 25) chk("land_pulse", int'(ld_o[0]), 1);
      step(1'b0, 1'b0, 1'b0);
      if (k == 25) chk("land_pulse_drop", int'(ld_o[0]), 0);
    end

    // async reset mid-air with the button held through release
    press_jump(1'b0);
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
    end
    chk("midair_y", int'(y_o[0]), 54);
    do_reset(1'b1);
    chk("async_y", int'(y_o[0]), 104);
    chk("async_state", int'(st_o[0]), 0);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0);
    end
    chk("held_no_jump_y", int'(y_o[0]), 104);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk("repress_y", int'(y_o[0]), 92);
    step(1'b0, 1'b0, 1'b0);

    // randomized stimulus against the model
    jr = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0) jr = ~jr;
      if ($urandom_range(0, 699) == 0) do_reset(jr);
      else step($urandom_range(0, 2) == 0, jr, $urandom_range(0, 9) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
